// File: rtl/ddr_burst_arbiter_if.sv
// ddr_burst_arbiter_if
//   Bundles the arbiter's request, command, completion and status signals.
//   Two views are provided:
//     master - the arbiter itself. It drives burst commands and status, and
//              it samples requests, done pulses and busy flags.
//     slave  - the surrounding FIFO controllers and AXI master engine, which
//              sit on the opposite side of every signal.
//   Parameters:
//     ADDR_W - byte-address width; must match C_M_AXI_ADDR_WIDTH of the arbiter
//     FILL_W - width of fill_bursts; must equal clog2(BUF_BURSTS+1)
interface ddr_burst_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int FILL_W = 11
);
    logic              wr_req;
    logic              rd_req;
    logic              flush;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_len;
    logic              wr_done;
    logic              wr_busy;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_done;
    logic              rd_busy;
    logic [FILL_W-1:0] fill_bursts;
    logic              ring_full;
    logic              ring_empty;
    logic              seq_err;

    modport master (
        input  wr_req, rd_req, flush, wr_done, wr_busy, rd_done, rd_busy,
        output wr_start, wr_addr, wr_len, rd_start, rd_addr, rd_len,
               fill_bursts, ring_full, ring_empty, seq_err
    );

    modport slave (
        output wr_req, rd_req, flush, wr_done, wr_busy, rd_done, rd_busy,
        input  wr_start, wr_addr, wr_len, rd_start, rd_addr, rd_len,
               fill_bursts, ring_full, ring_empty, seq_err
    );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter
//   Shares one AXI burst master between a write path (ingress FIFO to DDR)
//   and a read path (DDR to egress FIFO). DDR is used as a ring buffer of
//   fixed-size bursts. One command is outstanding at a time. Write and read
//   alternate when both are eligible. Occupancy is tracked so that reads never
//   overtake writes and writes never overrun unread data.
//
//   Handshake: X_start is a one-cycle command. It is asserted in X_ISSUE
//   whenever X_busy is low, and the FSM leaves ISSUE in that same cycle.
//   X_addr is held stable until the cycle after X_done. X_done is a one-cycle
//   completion pulse and is accepted only in X_WAIT. Any other done pulse is
//   ignored and flagged on the sticky seq_err output.
//
//   Ports:
//     clk       - DDR system clock
//     rst       - synchronous, active-high reset
//     bus       - ddr_burst_arbiter_if.master. Carries the requests, flush,
//                 burst commands and addresses, done/busy from the master,
//                 and the fill, full/empty and seq_err status
//     state_dbg - current FSM state, for observation only
//
//   Parameters:
//     C_M_AXI_ADDR_WIDTH - byte-address width
//     C_M_AXI_DATA_WIDTH - AXI data width in bits
//     BURST_LEN          - beats per burst, 1..255
//     BUF_BASE           - ring start byte address, aligned to a burst
//     BUF_BURSTS         - ring capacity in bursts, at least 2
module ddr_burst_arbiter #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 128,
    parameter int                            BURST_LEN          = 16,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BUF_BASE           = '0,
    parameter int                            BUF_BURSTS         = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    ddr_burst_arbiter_if.master   bus,
    output logic [2:0]            state_dbg
);

    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int FW          = $clog2(BUF_BURSTS + 1);
    localparam int BURST_BYTES = BURST_LEN * (C_M_AXI_DATA_WIDTH / 8);

    // The ring end is computed one bit wider than an address, so that a ring
    // ending exactly at the top of the address space still compares correctly.
    localparam logic [AW:0]   BASE_X   = {1'b0, BUF_BASE};
    localparam logic [AW:0]   END_X    = {1'b0, BUF_BASE} + (AW+1)'(BUF_BURSTS * BURST_BYTES);
    localparam logic [AW:0]   STEP_X   = (AW+1)'(BURST_BYTES);
    localparam logic [FW-1:0] FULL_CNT = FW'(BUF_BURSTS);
    localparam logic [7:0]    LEN8     = 8'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4
    } state_t;

    state_t        state, state_nx;
    logic          last_rd;      // 1: the most recent grant went to the read side
    logic          flush_pend;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0] fill, fill_nx;
    logic          full_q, empty_q, seq_err_q;

    logic wr_ok, rd_ok, flush_now, grant_wr, grant_rd, wr_adv, rd_adv, seq_hit;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        logic [AW:0] n;
        n = {1'b0, p} + STEP_X;
        if (n == END_X) n = BASE_X;
        return n[AW-1:0];
    endfunction

    always_comb begin
        wr_ok     = bus.wr_req && !full_q;
        rd_ok     = bus.rd_req && !empty_q;
        // A flush is applied only in IDLE. While it is being applied, no grant
        // is made, so that eligibility is evaluated on the emptied ring.
        flush_now = (state == S_IDLE) && (bus.flush || flush_pend);
        wr_adv    = (state == S_WR_WAIT) && bus.wr_done;
        rd_adv    = (state == S_RD_WAIT) && bus.rd_done;
        seq_hit   = (bus.wr_done && state != S_WR_WAIT) ||
                    (bus.rd_done && state != S_RD_WAIT);

        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == S_IDLE && !flush_now) begin
            if (wr_ok && rd_ok) begin
                grant_wr = last_rd;
                grant_rd = !last_rd;
            end else begin
                grant_wr = wr_ok;
                grant_rd = rd_ok;
            end
        end

        state_nx = state;
        case (state)
            S_IDLE: begin
                if (grant_wr)      state_nx = S_WR_ISSUE;
                else if (grant_rd) state_nx = S_RD_ISSUE;
            end
            S_WR_ISSUE: if (!bus.wr_busy) state_nx = S_WR_WAIT;
            S_WR_WAIT:  if (bus.wr_done)  state_nx = S_IDLE;
            S_RD_ISSUE: if (!bus.rd_busy) state_nx = S_RD_WAIT;
            S_RD_WAIT:  if (bus.rd_done)  state_nx = S_IDLE;
            default:                      state_nx = S_IDLE;
        endcase

        fill_nx = fill;
        if (flush_now)   fill_nx = '0;
        else if (wr_adv) fill_nx = fill + 1'b1;
        else if (rd_adv) fill_nx = fill - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_rd    <= 1'b1;
            flush_pend <= 1'b0;
            wr_ptr     <= BUF_BASE;
            rd_ptr     <= BUF_BASE;
            fill       <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            seq_err_q  <= 1'b0;
        end else begin
            state <= state_nx;

            if (grant_wr)      last_rd <= 1'b0;
            else if (grant_rd) last_rd <= 1'b1;

            // A flush that arrives outside IDLE waits for the outstanding done.
            // That done's pointer and fill update happens first.
            if (flush_now)                           flush_pend <= 1'b0;
            else if (bus.flush && state != S_IDLE)   flush_pend <= 1'b1;

            if (flush_now) begin
                wr_ptr <= BUF_BASE;
                rd_ptr <= BUF_BASE;
            end else begin
                if (wr_adv) wr_ptr <= next_ptr(wr_ptr);
                if (rd_adv) rd_ptr <= next_ptr(rd_ptr);
            end

            fill    <= fill_nx;
            full_q  <= (fill_nx == FULL_CNT);
            empty_q <= (fill_nx == '0);

            if (seq_hit) seq_err_q <= 1'b1;
        end
    end

    assign bus.wr_start    = (state == S_WR_ISSUE) && !bus.wr_busy;
    assign bus.rd_start    = (state == S_RD_ISSUE) && !bus.rd_busy;
    assign bus.wr_addr     = wr_ptr;
    assign bus.rd_addr     = rd_ptr;
    assign bus.wr_len      = LEN8;
    assign bus.rd_len      = LEN8;
    assign bus.fill_bursts = fill;
    assign bus.ring_full   = full_q;
    assign bus.ring_empty  = empty_q;
    assign bus.seq_err     = seq_err_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter
//   Directed bench for ddr_burst_arbiter. The ring is 4 bursts of 256 bytes
//   (16 beats x 16 bytes), based at 0. Inputs change 1 ns after a rising edge.
//   Outputs are sampled at that same point.
module tb_ddr_burst_arbiter;

  localparam int AW = 32;
  localparam int FW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  ddr_burst_arbiter_if #(.ADDR_W(AW), .FILL_W(FW)) bus ();

  ddr_burst_arbiter #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (128),
    .BURST_LEN          (16),
    .BUF_BASE           (32'h0000_0000),
    .BUF_BURSTS         (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the start of one side, then checks the latency and the address.
  // It then checks that nothing is issued in WAIT, and returns the matching done.
  task automatic do_burst(input string name, input bit is_wr,
                          input logic [31:0] exp_addr, input int exp_lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (is_wr ? bus.wr_start : bus.rd_start) seen = 1'b1;
    end
    chk({name, "/start_seen"}, 64'(seen), 64'd1);
    chk({name, "/latency"}, 64'(n), 64'(exp_lat));
    chk({name, "/other_start"}, 64'(is_wr ? bus.rd_start : bus.wr_start), 64'd0);
    chk({name, "/addr"}, 64'(is_wr ? bus.wr_addr : bus.rd_addr), 64'(exp_addr));
    tick();
    chk({name, "/no_start_in_wait"}, 64'(bus.wr_start | bus.rd_start), 64'd0);
    if (is_wr) bus.wr_done = 1'b1;
    else       bus.rd_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  initial begin
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_done = 1'b0;
    bus.wr_busy = 1'b0;
    bus.rd_done = 1'b0;
    bus.rd_busy = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    chk("rst/wr_start", 64'(bus.wr_start), 64'd0);
    chk("rst/rd_start", 64'(bus.rd_start), 64'd0);
    chk("rst/wr_addr", 64'(bus.wr_addr), 64'h0);
    chk("rst/rd_addr", 64'(bus.rd_addr), 64'h0);
    chk("rst/fill", 64'(bus.fill_bursts), 64'd0);
    chk("rst/empty", 64'(bus.ring_empty), 64'd1);
    chk("rst/full", 64'(bus.ring_full), 64'd0);
    chk("rst/seq_err", 64'(bus.seq_err), 64'd0);
    chk("rst/wr_len", 64'(bus.wr_len), 64'd16);
    chk("rst/rd_len", 64'(bus.rd_len), 64'd16);
    chk("rst/state", 64'(state_dbg), 64'd0);

    // first write: address 0, then the pointer moves by 256
    bus.wr_req = 1'b1;
    do_burst("w0", 1'b1, 32'h000, 1);
    chk("w0/fill", 64'(bus.fill_bursts), 64'd1);
    chk("w0/wr_addr_next", 64'(bus.wr_addr), 64'h100);
    chk("w0/empty", 64'(bus.ring_empty), 64'd0);
    chk("w0/rd_addr", 64'(bus.rd_addr), 64'h0);
    do_burst("w1", 1'b1, 32'h100, 1);
    chk("w1/fill", 64'(bus.fill_bursts), 64'd2);

    // both sides requesting: the last grant was a write, so the read goes first
    bus.rd_req = 1'b1;
    do_burst("alt_r0", 1'b0, 32'h000, 1);
    chk("alt_r0/fill", 64'(bus.fill_bursts), 64'd1);
    do_burst("alt_w2", 1'b1, 32'h200, 1);
    do_burst("alt_r1", 1'b0, 32'h100, 1);
    do_burst("alt_w3", 1'b1, 32'h300, 1);
    bus.rd_req = 1'b0;
    chk("wrap/wr_addr", 64'(bus.wr_addr), 64'h000);
    chk("wrap/fill", 64'(bus.fill_bursts), 64'd2);

    // fill to capacity
    do_burst("fill_w0", 1'b1, 32'h000, 1);
    do_burst("fill_w1", 1'b1, 32'h100, 1);
    chk("full/fill", 64'(bus.fill_bursts), 64'd4);
    chk("full/flag", 64'(bus.ring_full), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full/wr_start_blocked", 64'(bus.wr_start), 64'd0);
    end
    chk("full/state_idle", 64'(state_dbg), 64'd0);

    // one read frees a slot, and the write then resumes
    bus.rd_req = 1'b1;
    do_burst("full_r", 1'b0, 32'h200, 1);
    chk("full_r/full", 64'(bus.ring_full), 64'd0);
    chk("full_r/fill", 64'(bus.fill_bursts), 64'd3);
    do_burst("resume_w", 1'b1, 32'h200, 1);
    chk("resume_w/full", 64'(bus.ring_full), 64'd1);
    bus.wr_req = 1'b0;

    // drain the ring
    do_burst("drain_r0", 1'b0, 32'h300, 1);
    do_burst("drain_r1", 1'b0, 32'h000, 1);
    do_burst("drain_r2", 1'b0, 32'h100, 1);
    do_burst("drain_r3", 1'b0, 32'h200, 1);
    chk("drain/fill", 64'(bus.fill_bursts), 64'd0);
    chk("drain/empty", 64'(bus.ring_empty), 64'd1);
    chk("drain/rd_addr", 64'(bus.rd_addr), 64'h300);

    // read requested on an empty ring: never issued
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("empty/rd_start_blocked", 64'(bus.rd_start), 64'd0);
    end

    // write held off by busy for 5 cycles
    bus.wr_busy = 1'b1;
    bus.wr_req  = 1'b1;
    tick();
    chk("busy/state_issue", 64'(state_dbg), 64'd1);
    chk("busy/wr_start_c0", 64'(bus.wr_start), 64'd0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("busy/wr_start_held", 64'(bus.wr_start), 64'd0);
    end
    bus.wr_busy = 1'b0;
    #1;
    chk("busy/wr_start_release", 64'(bus.wr_start), 64'd1);
    chk("busy/wr_addr", 64'(bus.wr_addr), 64'h300);
    tick();
    chk("busy/wait_no_start", 64'(bus.wr_start), 64'd0);
    chk("busy/state_wait", 64'(state_dbg), 64'd2);
    bus.wr_req  = 1'b0;
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("busy/fill", 64'(bus.fill_bursts), 64'd1);
    chk("busy/wr_addr_wrap", 64'(bus.wr_addr), 64'h000);

    // the pending read follows the completed write
    do_burst("after_w_r", 1'b0, 32'h300, 1);
    chk("after_w_r/empty", 64'(bus.ring_empty), 64'd1);
    bus.wr_req = 1'b1;
    do_burst("pre_w", 1'b1, 32'h000, 1);
    do_burst("pre_r", 1'b0, 32'h000, 1);
    bus.rd_req = 1'b0;
    chk("pre/rd_addr", 64'(bus.rd_addr), 64'h100);

    // flush during WR_WAIT, then wr_done
    tick();
    chk("flush/wr_start", 64'(bus.wr_start), 64'd1);
    chk("flush/wr_addr", 64'(bus.wr_addr), 64'h100);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush/still_wait", 64'(state_dbg), 64'd2);
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("flush/fill_after_done", 64'(bus.fill_bursts), 64'd1);
    chk("flush/wr_addr_after_done", 64'(bus.wr_addr), 64'h200);
    chk("flush/idle", 64'(state_dbg), 64'd0);
    tick();
    chk("flush/fill_cleared", 64'(bus.fill_bursts), 64'd0);
    chk("flush/wr_addr_base", 64'(bus.wr_addr), 64'h000);
    chk("flush/rd_addr_base", 64'(bus.rd_addr), 64'h000);
    chk("flush/empty", 64'(bus.ring_empty), 64'd1);
    chk("flush/no_grant_while_pending", 64'(state_dbg), 64'd0);
    bus.wr_req = 1'b0;

    // stray rd_done in IDLE
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    chk("stray/seq_err", 64'(bus.seq_err), 64'd1);
    chk("stray/rd_addr", 64'(bus.rd_addr), 64'h000);
    chk("stray/fill", 64'(bus.fill_bursts), 64'd0);
    repeat (2) tick();
    chk("stray/seq_err_sticky", 64'(bus.seq_err), 64'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2/seq_err", 64'(bus.seq_err), 64'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
